// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and dmem-side signals around the data-memory arbiter.
// slave is the arbiter's view; master is the view of the requesters and dmem together.
interface dmem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid;
  logic            req0_wr;
  logic [XLEN-1:0] req0_addr;
  logic [XLEN-1:0] req0_wdata;
  logic            req0_ready;
  logic            req0_rvalid;
  logic [XLEN-1:0] req0_rdata;

  logic            req1_valid;
  logic            req1_wr;
  logic [XLEN-1:0] req1_addr;
  logic [XLEN-1:0] req1_wdata;
  logic            req1_ready;
  logic            req1_rvalid;
  logic [XLEN-1:0] req1_rdata;

  logic            mem_en;
  logic            mem_wr;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            busy;

  modport slave (
    input  req0_valid, req0_wr, req0_addr, req0_wdata,
    output req0_ready, req0_rvalid, req0_rdata,
    input  req1_valid, req1_wr, req1_addr, req1_wdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output req0_valid, req0_wr, req0_addr, req0_wdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    output req1_valid, req1_wr, req1_addr, req1_wdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the MEM stage (port 0)
// and the loader/debug port (port 1); read responses are steered back after MEM_LAT cycles.
module dmem_arbiter #(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  logic               last_grant;
  logic               grant0;
  logic               grant1;
  logic               rd_accept;
  logic [MEM_LAT-1:0] trk_vld;
  logic [MEM_LAT-1:0] trk_own;

  // last_grant == 1 means port 1 won most recently, so port 0 wins the next tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.mem_en     = grant0 | grant1;
  assign bus.mem_wr     = (grant0 & bus.req0_wr) | (grant1 & bus.req1_wr);
  assign bus.mem_addr   = grant1 ? bus.req1_addr  : bus.req0_addr;
  assign bus.mem_wdata  = grant1 ? bus.req1_wdata : bus.req0_wdata;

  assign rd_accept = (grant0 & ~bus.req0_wr) | (grant1 & ~bus.req1_wr);

  // Tracking pipe: bit 0 is loaded on the accept edge, bit MEM_LAT-1 is the response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      trk_vld    <= '0;
      trk_own    <= '0;
    end else begin
      trk_vld <= (MEM_LAT)'({trk_vld, rd_accept});
      trk_own <= (MEM_LAT)'({trk_own, grant1});
      if (grant0 || grant1) begin
        last_grant <= grant1;
      end
    end
  end

  assign bus.req0_rvalid = trk_vld[MEM_LAT-1] & ~trk_own[MEM_LAT-1];
  assign bus.req1_rvalid = trk_vld[MEM_LAT-1] &  trk_own[MEM_LAT-1];
  assign bus.req0_rdata  = bus.mem_rdata;
  assign bus.req1_rdata  = bus.mem_rdata;
  assign bus.busy        = |trk_vld;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (MEM_LAT 1, 2, 3) share one directed stimulus,
// a per-cycle reference model checks all outputs, literal checks pin the key scenarios.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        v0, w0, v1, w1;
  logic [31:0] a0, d0, a1, d1;

  logic [2:0]  rdy0, rdy1, en, wr, rv0, rv1, bsy;
  logic [31:0] maddr [3];
  logic [31:0] mwdata[3];
  logic [31:0] rd0   [3];
  logic [31:0] rd1   [3];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] addr);
    return (addr == 32'h100) ? 32'hDEADBEEF : {addr[15:0], ~addr[15:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_arbiter_if #(.XLEN(32)) bus ();
    dmem_arbiter #(.XLEN(32), .MEM_LAT(g + 1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    logic [31:0] pipe [4];

    assign bus.req0_valid = v0;
    assign bus.req0_wr    = w0;
    assign bus.req0_addr  = a0;
    assign bus.req0_wdata = d0;
    assign bus.req1_valid = v1;
    assign bus.req1_wr    = w1;
    assign bus.req1_addr  = a1;
    assign bus.req1_wdata = d1;
    assign bus.mem_rdata  = pipe[g];

    assign rdy0[g]   = bus.req0_ready;
    assign rdy1[g]   = bus.req1_ready;
    assign en[g]     = bus.mem_en;
    assign wr[g]     = bus.mem_wr;
    assign rv0[g]    = bus.req0_rvalid;
    assign rv1[g]    = bus.req1_rvalid;
    assign bsy[g]    = bus.busy;
    assign maddr[g]  = bus.mem_addr;
    assign mwdata[g] = bus.mem_wdata;
    assign rd0[g]    = bus.req0_rdata;
    assign rd1[g]    = bus.req1_rdata;

    // dmem with fixed read latency; returns zero when no read is due
    always @(posedge clk) begin
      pipe[0] <= (bus.mem_en && !bus.mem_wr) ? mem_val(bus.mem_addr) : 32'h0;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // history of observed outputs, indexed by cycle
  logic        h_en  [512];
  logic        h_wr  [512];
  logic        h_rdy0[512];
  logic        h_rdy1[512];
  logic [31:0] h_addr[512];
  logic [31:0] h_wd  [512];
  logic [31:0] h_rd0 [512];
  logic        h_rv0 [3][512];
  logic        h_rv1 [3][512];
  logic        h_bsy [3][512];

  // reference model state
  int          m_last = 1;
  logic        sch_v [3][16];
  logic        sch_o [3][16];
  logic [31:0] sch_d [3][16];
  int          pending[3];

  always @(negedge clk) begin
    int          win;
    logic        has;
    logic        e_wr;
    logic [31:0] e_addr, e_wd;
    int          slot;
    if (!rst_n) begin
      m_last = 1;
      for (int k = 0; k < 3; k++) begin
        pending[k] = 0;
        for (int s = 0; s < 16; s++) sch_v[k][s] = 1'b0;
      end
    end
    has    = rst_n && (v0 || v1);
    win    = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v1 ? 1 : 0);
    e_wr   = has ? ((win == 1) ? w1 : w0) : 1'b0;
    e_addr = (has && win == 1) ? a1 : a0;
    e_wd   = (has && win == 1) ? d1 : d0;
    slot   = cyc % 16;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("L%0d ready0", k + 1), 32'(rdy0[k]), 32'(has && win == 0));
      chk($sformatf("L%0d ready1", k + 1), 32'(rdy1[k]), 32'(has && win == 1));
      chk($sformatf("L%0d mem_en", k + 1), 32'(en[k]), 32'(has));
      chk($sformatf("L%0d mem_wr", k + 1), 32'(wr[k]), 32'(e_wr));
      chk($sformatf("L%0d mem_addr", k + 1), maddr[k], e_addr);
      chk($sformatf("L%0d mem_wdata", k + 1), mwdata[k], e_wd);
      chk($sformatf("L%0d rvalid0", k + 1), 32'(rv0[k]), 32'(sch_v[k][slot] && !sch_o[k][slot]));
      chk($sformatf("L%0d rvalid1", k + 1), 32'(rv1[k]), 32'(sch_v[k][slot] && sch_o[k][slot]));
      chk($sformatf("L%0d busy", k + 1), 32'(bsy[k]), 32'(pending[k] != 0));
      if (sch_v[k][slot]) begin
        if (sch_o[k][slot]) chk($sformatf("L%0d rdata1", k + 1), rd1[k], sch_d[k][slot]);
        else                chk($sformatf("L%0d rdata0", k + 1), rd0[k], sch_d[k][slot]);
        sch_v[k][slot] = 1'b0;
        pending[k]--;
      end
      if (has && !e_wr) begin
        sch_v[k][(cyc + k + 1) % 16] = 1'b1;
        sch_o[k][(cyc + k + 1) % 16] = (win == 1);
        sch_d[k][(cyc + k + 1) % 16] = mem_val(e_addr);
        pending[k]++;
      end
    end
    if (has) m_last = win;
    if (cyc < 512) begin
      h_en[cyc]   = en[0];
      h_wr[cyc]   = wr[0];
      h_rdy0[cyc] = rdy0[0];
      h_rdy1[cyc] = rdy1[0];
      h_addr[cyc] = maddr[0];
      h_wd[cyc]   = mwdata[0];
      h_rd0[cyc]  = rd0[0];
      for (int k = 0; k < 3; k++) begin
        h_rv0[k][cyc] = rv0[k];
        h_rv1[k][cyc] = rv1[k];
        h_bsy[k][cyc] = bsy[k];
      end
    end
    cyc++;
  end

  task automatic drive(input logic iv0, input logic iw0, input logic [31:0] ia0, input logic [31:0] id0,
                       input logic iv1, input logic iw1, input logic [31:0] ia1, input logic [31:0] id1);
    v0 = iv0; w0 = iw0; a0 = ia0; d0 = id0;
    v1 = iv1; w1 = iw1; a1 = ia1; d1 = id1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    logic [31:0] exp_addr [5];
    logic        exp_g1   [5];
    rst_n = 1'b0;
    v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    v1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single port 0 read after reset
    t0 = cyc;
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(4);
    chk("t1 ready0", 32'(h_rdy0[t0]), 32'd1);
    chk("t1 mem_en", 32'(h_en[t0]), 32'd1);
    chk("t1 mem_wr", 32'(h_wr[t0]), 32'd0);
    chk("t1 mem_addr", h_addr[t0], 32'h100);
    chk("t1 rvalid0", 32'(h_rv0[0][t0+1]), 32'd1);
    chk("t1 rdata0", h_rd0[t0+1], 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) chk("t1 rvalid1", 32'(h_rv1[0][t0+i]), 32'd0);
    chk("t1 rvalid0 L3", 32'(h_rv0[2][t0+3]), 32'd1);

    // port 1 write produces no read response
    t0 = cyc;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h55AA55AA);
    idle(5);
    chk("t4 ready1", 32'(h_rdy1[t0]), 32'd1);
    chk("t4 mem_wr", 32'(h_wr[t0]), 32'd1);
    chk("t4 mem_addr", h_addr[t0], 32'h40);
    chk("t4 mem_wdata", h_wd[t0], 32'h55AA55AA);
    for (int i = 1; i <= 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        chk("t4 rvalid0", 32'(h_rv0[k][t0+i]), 32'd0);
        chk("t4 rvalid1", 32'(h_rv1[k][t0+i]), 32'd0);
      end
    end

    // contention: grants alternate 0,1,0,1 then the leftover port 0 request
    t0 = cyc;
    drive(1'b1, 1'b1, 32'h10, 32'hA0, 1'b1, 1'b1, 32'h20, 32'hB0);
    drive(1'b1, 1'b1, 32'h11, 32'hA1, 1'b1, 1'b1, 32'h20, 32'hB0);
    drive(1'b1, 1'b1, 32'h11, 32'hA1, 1'b1, 1'b1, 32'h21, 32'hB1);
    drive(1'b1, 1'b1, 32'h12, 32'hA2, 1'b1, 1'b1, 32'h21, 32'hB1);
    drive(1'b1, 1'b1, 32'h12, 32'hA2, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(2);
    exp_addr = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12};
    exp_g1   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      chk("t2 mem_addr", h_addr[t0+i], exp_addr[i]);
      chk("t2 ready0", 32'(h_rdy0[t0+i]), 32'(!exp_g1[i]));
      chk("t2 ready1", 32'(h_rdy1[t0+i]), 32'(exp_g1[i]));
    end

    // back-to-back reads observed on the MEM_LAT=3 instance
    t0 = cyc;
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(6);
    chk("t3 rvalid0 c3", 32'(h_rv0[2][t0+3]), 32'd1);
    chk("t3 rvalid1 c3", 32'(h_rv1[2][t0+3]), 32'd0);
    chk("t3 rvalid1 c4", 32'(h_rv1[2][t0+4]), 32'd1);
    chk("t3 rvalid0 c4", 32'(h_rv0[2][t0+4]), 32'd0);
    chk("t3 rvalid0 c5", 32'(h_rv0[2][t0+5]), 32'd1);
    chk("t3 rvalid0 c2", 32'(h_rv0[2][t0+2]), 32'd0);
    chk("t3 busy c0", 32'(h_bsy[2][t0]), 32'd0);
    for (int i = 1; i <= 5; i++) chk("t3 busy", 32'(h_bsy[2][t0+i]), 32'd1);
    chk("t3 busy c6", 32'(h_bsy[2][t0+6]), 32'd0);

    // idle keeps last_grant (port 0 last), so the next tie goes to port 1
    t0 = cyc;
    idle(10);
    for (int i = 0; i < 10; i++) begin
      chk("t6 mem_en", 32'(h_en[t0+i]), 32'd0);
      chk("t6 ready0", 32'(h_rdy0[t0+i]), 32'd0);
      chk("t6 ready1", 32'(h_rdy1[t0+i]), 32'd0);
    end
    t0 = cyc;
    drive(1'b1, 1'b1, 32'h30, 32'h1, 1'b1, 1'b1, 32'h34, 32'h2);
    drive(1'b1, 1'b1, 32'h30, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(2);
    chk("t6 tie ready1", 32'(h_rdy1[t0]), 32'd1);
    chk("t6 tie addr", h_addr[t0], 32'h34);

    // reset while a read is in flight
    t0 = cyc;
    drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(4);
    drive(1'b1, 1'b1, 32'h50, 32'h3, 1'b1, 1'b1, 32'h54, 32'h4);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h54, 32'h4);
    idle(2);
    chk("t5 accept", 32'(h_rdy0[t0]), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      for (int k = 0; k < 3; k++) begin
        chk("t5 rvalid0", 32'(h_rv0[k][t0+i]), 32'd0);
        chk("t5 busy", 32'(h_bsy[k][t0+i]), 32'd0);
      end
    end
    chk("t5 tie ready0", 32'(h_rdy0[t0+6]), 32'd1);
    chk("t5 tie ready1", 32'(h_rdy1[t0+6]), 32'd0);
    chk("t5 tie addr", h_addr[t0+6], 32'h50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters.
  - Port 0: the pipeline MEM stage.
  - Port 1: the program loader / debug port.
- Arbitrates with round-robin priority, accepts at most one access per cycle, and drives dmem enable, write, address and data.
- Tracks in-flight reads and steers each read response back to the requester that issued it, with a fixed latency.
- Sits between the MEM stage, the loader and dmem. A low req0_ready is the MEM-stage stall.

Parameters:
- XLEN, 32, data and address width.
- MEM_LAT, 1, dmem read latency in cycles from accept to valid mem_rdata. Legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req0_valid  in  1  port 0 request valid.
- req0_wr  in  1  port 0 access type: 1 write, 0 read.
- req0_addr  in  XLEN  port 0 byte address.
- req0_wdata  in  XLEN  port 0 write data.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_rvalid  out  1  port 0 read data valid.
- req0_rdata  out  XLEN  port 0 read data.
- req1_valid, req1_wr, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same as port 0, for port 1.
- mem_en  out  1  dmem enable.
- mem_wr  out  1  dmem write enable.
- mem_addr  out  XLEN  dmem address.
- mem_wdata  out  XLEN  dmem write data.
- mem_rdata  in  XLEN  dmem read data, valid MEM_LAT cycles after an accepted read.
- busy  out  1  at least one read is in flight.

Behaviour:
- Reset (rst_n low, asynchronous):
  - last_grant = 1, so port 0 wins the first tie.
  - All in-flight tracking bits cleared.
  - req0_rvalid = req1_rvalid = 0, busy = 0.
  - req0_ready, req1_ready and mem_en are forced to 0 while rst_n is low.
- Arbitration (combinational, every cycle):
  - Only req0_valid high: grant port 0.
  - Only req1_valid high: grant port 1.
  - Both high: grant the port that is not last_grant.
  - Neither high: no grant; mem_en = 0, mem_wr = 0.
  - reqN_ready = 1 exactly for the granted port. The ready of an invalid port is 0.
- Issue:
  - On a grant, mem_en = 1 and mem_wr = reqN_wr.
  - mem_addr and mem_wdata come from the granted port.
  - dmem samples these on the same rising edge; this is the accept edge.
  - When there is no grant, mem_addr and mem_wdata hold the port 0 values; this is don't-care, but must be deterministic.
- last_grant updates to the granted port on every accept edge, and holds when there is no grant.
- Writes:
  - Complete on the accept edge.
  - Produce no rvalid.
  - One write per cycle is allowed back-to-back.
- Reads:
  - Each accepted read enters a MEM_LAT-deep tracking pipe. Each stage holds a valid bit and an owner bit.
  - Exactly MEM_LAT cycles after the accept edge, reqOwner_rvalid = 1 for one cycle, and the other port's rvalid = 0.
  - req0_rdata and req1_rdata are both driven from mem_rdata at all times; rvalid qualifies them.
  - Reads are fully pipelined: one read may be accepted every cycle. Responses return in accept order and never collide, since at most one accept occurs per cycle.
- Handshake:
  - A requester holds valid, wr, addr and wdata stable until ready.
  - The arbiter does not buffer requests.
  - A requester may drop valid only after acceptance.
- busy = OR of all tracking valid bits.
- Mixed traffic: a write may be accepted while reads are in flight. No ordering hazard is resolved here; the MEM stage is the sole writer during normal execution.
- Reset mid-operation: in-flight reads are discarded, and no rvalid is produced for them after rst_n rises.
- Fairness: under continuous contention the grants alternate 0,1,0,1,… Neither port waits more than one cycle while the other is valid.

Test Plan:
- Reset release, then port 0 read to 0x100 with dmem returning 0xDEADBEEF:
  - req0_ready = 1 in cycle 0 and mem_en = 1, mem_wr = 0, mem_addr = 0x100.
  - req0_rvalid = 1 with rdata 0xDEADBEEF in cycle MEM_LAT (cycle 1 at default).
  - req1_rvalid stays 0.
- Both ports valid for 4 cycles:
  - Port 0 writes 0x10/0x11, port 1 writes 0x20/0x21.
  - Grants are 0,1,0,1; mem_addr sequence is 0x10, 0x20, 0x11, 0x21.
  - Each ready is high only in its grant cycle.
- Back-to-back reads at MEM_LAT = 3:
  - Port 0 reads 0x0, port 1 reads 0x4, port 0 reads 0x8, on consecutive cycles.
  - rvalid appears in cycles 3, 4, 5 with owners 0, 1, 0.
  - busy is high in cycles 1 through 5 and low in cycle 6.
- Write does not produce rvalid:
  - Port 1 writes 0x55AA55AA to 0x40 → mem_wr = 1, mem_wdata = 0x55AA55AA.
  - No rvalid appears on either port in the following 4 cycles.
- Reset mid-flight:
  - Port 0 read is accepted at MEM_LAT = 2, then rst_n is pulsed low 1 cycle later.
  - No rvalid appears afterwards, busy = 0, and the next tie grants port 0.
- Idle:
  - Both valid inputs are low for 10 cycles.
  - mem_en = 0 and both readys = 0 throughout.
  - last_grant is unchanged, verified by the next tie going to the expected port.
